// File: rtl/pipe_stage_sreg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional macro PIPE_SREG_PERF_EN builds a saturating stall-cycle counter on o_stall_cnt.
module pipe_stage_sreg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_valid;
  logic              r_ready;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_in_xfer  = i_valid && r_ready;
  assign w_out_xfer = r_valid && i_ready;

  // Next-state and storage update; flush overrides any handshake on the same edge
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (i_flush) begin
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = '0;
      w_main_data_nxt = '0;
      w_skid_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt     = ST_BUSY;
            w_main_ctrl_nxt = i_ctrl;
            w_main_data_nxt = i_data;
          end
        end
        ST_BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_ctrl_nxt = i_ctrl;
            w_main_data_nxt = i_data;
          end else if (w_in_xfer) begin
            w_state_nxt     = ST_FULL;
            w_skid_ctrl_nxt = i_ctrl;
            w_skid_data_nxt = i_data;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_state_nxt     = ST_BUSY;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered decodes of the next state, so i_ready never reaches o_ready
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= ST_EMPTY;
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_valid     <= (w_state_nxt != ST_EMPTY);
      r_ready     <= (w_state_nxt != ST_FULL);
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_ready = r_ready;
  assign o_ctrl  = r_main_ctrl;
  assign o_data  = r_main_data;

`ifdef PIPE_SREG_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of edges where downstream holds off a valid entry; flush leaves it alone
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !i_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
